hazard_stall_controller: RTL

- Pipeline sequencing controller for the 5-stage ARM core; owns every stall, freeze and flush decision that operand forwarding cannot resolve.
- Detects RAW hazards in ID against the EXE and MEM destinations.
  - forward_en=1: only load-use hazards are detected.
  - forward_en=0: all RAW hazards are detected.
- Runs a FSM that freezes the whole pipe while the MEM stage waits on the SRAM, and generates the branch flush.
- Keeps saturating performance counters.

---
 rtl/hazard_stall_controller.sv | 122 ++++++++++++
 1 files changed

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: RAW hazard stall, SRAM-wait freeze, branch flush, perf counters.
// Latency: stall/freeze/flush are combinational (same cycle); FSM, timeout and counters update on the next edge.
// Backpressure: freeze holds the whole pipe while MEM waits on SRAM; priority is freeze > flush > hazard_stall.
module hazard_stall_controller #(
    parameter int CNT_W        = 16,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             forward_en,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             two_src,
    input  logic             id_valid,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             hazard_stall,
    output logic             freeze,
    output logic             flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int WC_W = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state_q;
    logic [WC_W-1:0]   wait_cnt_q;
    logic              mem_timeout_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  freeze_cnt_q;

    logic m_exe;
    logic m_mem;
    logic raw;
    logic wait_start;

    // Destination matches and the RAW term; with forwarding only a load in EXE cannot be bypassed.
    always_comb begin
        m_exe = exe_wb_en & ((exe_dest == src1) | (two_src & (exe_dest == src2)));
        m_mem = mem_wb_en & ((mem_dest == src1) | (two_src & (mem_dest == src2)));
        if (forward_en) begin
            raw = id_valid & exe_mem_r_en & m_exe;
        end else begin
            raw = id_valid & (m_exe | m_mem);
        end
    end

    // Pipeline control outputs, all held low while reset is asserted.
    always_comb begin
        wait_start   = (state_q == RUN) & mem_req & ~mem_ready;
        freeze       = ~rst & ((state_q == MEM_WAIT) | wait_start);
        flush        = ~rst & branch_taken & ~freeze;
        hazard_stall = ~rst & raw & ~freeze & ~flush;
    end

    // SRAM wait FSM with consecutive-wait counter and forced release on timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WC_W'(WAIT_TIMEOUT)) begin
                        // Give up on the access so the core is not hung forever; the error stays sticky.
                        state_q       <= RUN;
                        wait_cnt_q    <= '0;
                        mem_timeout_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                default: begin
                    state_q    <= RUN;
                    wait_cnt_q <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters for stall and freeze cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            if (hazard_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (freeze && (freeze_cnt_q != '1)) begin
                freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign freeze_cnt  = freeze_cnt_q;

endmodule
